// File: rtl/jtdsp16_do_cache.sv
// Loop cache for the DSP16 "do K {NI}" / "redo K" forms: captures the body from
// the ROM fetch stream on the first pass, then replays it from a small cache.
module jtdsp16_do_cache #(
  parameter int DEPTH = 15,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          do_start,
  input  logic [10:0]   do_data,
  input  logic          inst_adv,
  input  logic [DW-1:0] rom_dout,
  output logic [DW-1:0] cache_dout,
  output logic          cache_sel,
  output logic          pc_hold,
  output logic          no_int,
  output logic [6:0]    iter_left,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, CAPTURE, REPLAY} state_t;

  state_t        state;
  logic [3:0]    ptr;
  logic [3:0]    last_ni;
  logic [6:0]    k_reg;
  logic [DW-1:0] mem [0:DEPTH-1];

  logic [3:0] ni;
  logic [6:0] k;
  logic       at_end;

  assign ni     = do_data[10:7];
  assign k      = do_data[6:0];
  assign at_end = (ptr == last_ni - 4'd1);

  // Contents are deliberately not reset; only CAPTURE ever writes.
  always_ff @(posedge clk) begin
    if (cen && inst_adv && state == CAPTURE)
      mem[ptr] <= rom_dout;
  end

  assign cache_dout = mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 4'd0;
      last_ni   <= 4'd0;
      k_reg     <= 7'd0;
      iter_left <= 7'd0;
      err       <= 1'b0;
      cache_sel <= 1'b0;
      pc_hold   <= 1'b0;
      no_int    <= 1'b0;
    end else if (cen) begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (do_start) begin
            if (ni != 4'd0) begin
              last_ni <= ni;
              k_reg   <= k;
              ptr     <= 4'd0;
              no_int  <= 1'b1;
              state   <= CAPTURE;
            end else if (last_ni != 4'd0) begin
              // redo: K passes in total, all from the cache
              ptr       <= 4'd0;
              iter_left <= (k == 7'd0) ? 7'd0 : k - 7'd1;
              cache_sel <= 1'b1;
              pc_hold   <= 1'b1;
              no_int    <= 1'b1;
              state     <= REPLAY;
            end else begin
              err <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          err <= do_start;
          if (inst_adv) begin
            if (at_end) begin
              ptr <= 4'd0;
              if (k_reg <= 7'd1) begin
                no_int <= 1'b0;
                state  <= IDLE;
              end else begin
                iter_left <= k_reg - 7'd2;
                cache_sel <= 1'b1;
                pc_hold   <= 1'b1;
                state     <= REPLAY;
              end
            end else begin
              ptr <= ptr + 4'd1;
            end
          end
        end
        REPLAY: begin
          err <= do_start;
          if (inst_adv) begin
            if (at_end) begin
              ptr <= 4'd0;
              if (iter_left != 7'd0) begin
                iter_left <= iter_left - 7'd1;
              end else begin
                cache_sel <= 1'b0;
                pc_hold   <= 1'b0;
                no_int    <= 1'b0;
                state     <= IDLE;
              end
            end else begin
              ptr <= ptr + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// Testbench for jtdsp16_do_cache: directed table, corner sequences and random
// traffic checked against a slot-queue reference model.
module tb_jtdsp16_do_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        do_start = 1'b0;
  logic [10:0] do_data = 11'd0;
  logic        inst_adv = 1'b0;
  logic [15:0] rom_dout = 16'd0;
  logic [15:0] cache_dout;
  logic        cache_sel, pc_hold, no_int, err;
  logic [6:0]  iter_left;

  jtdsp16_do_cache #(.DEPTH(15), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .do_start(do_start), .do_data(do_data),
    .inst_adv(inst_adv), .rom_dout(rom_dout), .cache_dout(cache_dout),
    .cache_sel(cache_sel), .pc_hold(pc_hold), .no_int(no_int),
    .iter_left(iter_left), .err(err)
  );

  always #5 clk = ~clk;

  // Model: the whole loop is a queue of fetch slots still to be consumed.
  typedef struct { bit rep; int idx; } slot_t;
  slot_t       q[$];
  int          m_last_ni = 0;
  bit          m_err = 1'b0;
  logic [15:0] m_mem [16];

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got %0h expected %0h", name, step_no, act, exp);
    end
  endtask

  task automatic push_passes(input int passes, input bit rep);
    slot_t s;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < m_last_ni; i++) begin
        s.rep = rep; s.idx = i; q.push_back(s);
      end
  endtask

  task automatic model_edge(input logic c, input logic ds, input logic [10:0] dd,
                            input logic adv, input logic [15:0] rom);
    bit    busy;
    int    ni, k;
    slot_t s;
    if (!c) return;
    busy = (q.size() != 0);
    ni = int'(dd[10:7]);
    k  = int'(dd[6:0]);
    m_err = 1'b0;
    if (ds) begin
      if (busy || (ni == 0 && m_last_ni == 0)) begin
        m_err = 1'b1;
      end else if (ni > 0) begin
        m_last_ni = ni;
        push_passes(1, 1'b0);
        push_passes((k > 1) ? k - 1 : 0, 1'b1);
      end else begin
        push_passes((k > 1) ? k : 1, 1'b1);
      end
    end
    if (busy && adv) begin
      s = q.pop_front();
      if (!s.rep) m_mem[s.idx] = rom;
    end
  endtask

  task automatic check_outputs();
    bit rep;
    rep = (q.size() > 0) && q[0].rep;
    chk("cache_sel", 32'(cache_sel), 32'(rep));
    chk("pc_hold", 32'(pc_hold), 32'(rep));
    chk("no_int", 32'(no_int), 32'(q.size() > 0));
    chk("err", 32'(err), 32'(m_err));
    chk("iter_left", 32'(iter_left), rep ? 32'((q.size() - 1) / m_last_ni) : 32'd0);
    if (rep) chk("cache_dout", 32'(cache_dout), 32'(m_mem[q[0].idx]));
  endtask

  task automatic step(input logic c, input logic ds, input logic [10:0] dd,
                      input logic adv, input logic [15:0] rom);
    cen = c; do_start = ds; do_data = dd; inst_adv = adv; rom_dout = rom;
    @(posedge clk);
    model_edge(c, ds, dd, adv, rom);
    #1;
    step_no++;
    check_outputs();
  endtask

  task automatic do_reset();
    cen = 1'b0; do_start = 1'b0; inst_adv = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_last_ni = 0;
    m_err = 1'b0;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic c; logic ds; logic [10:0] dd; logic adv; logic [15:0] rom;
    logic sel; logic nint; int iter; logic er; logic [15:0] dout;
  } vec_t;

  function automatic vec_t v(input logic c, input logic ds, input logic [10:0] dd,
                             input logic adv, input logic [15:0] rom, input logic sel,
                             input logic nint, input int iter, input logic er,
                             input logic [15:0] dout);
    vec_t r;
    r.c = c; r.ds = ds; r.dd = dd; r.adv = adv; r.rom = rom;
    r.sel = sel; r.nint = nint; r.iter = iter; r.er = er; r.dout = dout;
    return r;
  endfunction

  vec_t tbl [22];

  initial begin
    // redo after reset, do 3x3 capture/replay with cen gap and busy do, redo 2
    tbl[0]  = v(1, 1, 11'h002, 0, 16'h0000, 0, 0, 0, 1, 16'h0000);
    tbl[1]  = v(1, 0, 11'h000, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    tbl[2]  = v(1, 1, 11'h183, 1, 16'hFFFF, 0, 1, 0, 0, 16'h0000);
    tbl[3]  = v(1, 0, 11'h000, 1, 16'hA001, 0, 1, 0, 0, 16'h0000);
    tbl[4]  = v(1, 0, 11'h000, 0, 16'hDEAD, 0, 1, 0, 0, 16'h0000);
    tbl[5]  = v(1, 0, 11'h000, 1, 16'hB002, 0, 1, 0, 0, 16'h0000);
    tbl[6]  = v(1, 0, 11'h000, 1, 16'hC003, 1, 1, 1, 0, 16'hA001);
    tbl[7]  = v(1, 0, 11'h000, 1, 16'h0000, 1, 1, 1, 0, 16'hB002);
    tbl[8]  = v(0, 0, 11'h000, 1, 16'h0000, 1, 1, 1, 0, 16'hB002);
    tbl[9]  = v(1, 1, 11'h183, 0, 16'h0000, 1, 1, 1, 1, 16'hB002);
    tbl[10] = v(1, 0, 11'h000, 1, 16'h0000, 1, 1, 1, 0, 16'hC003);
    tbl[11] = v(1, 0, 11'h000, 1, 16'h0000, 1, 1, 0, 0, 16'hA001);
    tbl[12] = v(1, 0, 11'h000, 1, 16'h0000, 1, 1, 0, 0, 16'hB002);
    tbl[13] = v(1, 0, 11'h000, 1, 16'h0000, 1, 1, 0, 0, 16'hC003);
    tbl[14] = v(1, 0, 11'h000, 1, 16'h0000, 0, 0, 0, 0, 16'h0000);
    tbl[15] = v(1, 1, 11'h002, 0, 16'h0000, 1, 1, 1, 0, 16'hA001);
    tbl[16] = v(1, 0, 11'h000, 1, 16'h0000, 1, 1, 1, 0, 16'hB002);
    tbl[17] = v(1, 0, 11'h000, 1, 16'h0000, 1, 1, 1, 0, 16'hC003);
    tbl[18] = v(1, 0, 11'h000, 1, 16'h0000, 1, 1, 0, 0, 16'hA001);
    tbl[19] = v(1, 0, 11'h000, 1, 16'h0000, 1, 1, 0, 0, 16'hB002);
    tbl[20] = v(1, 0, 11'h000, 1, 16'h0000, 1, 1, 0, 0, 16'hC003);
    tbl[21] = v(1, 0, 11'h000, 1, 16'h0000, 0, 0, 0, 0, 16'h0000);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].c, tbl[i].ds, tbl[i].dd, tbl[i].adv, tbl[i].rom);
      chk("tbl_sel", 32'(cache_sel), 32'(tbl[i].sel));
      chk("tbl_hold", 32'(pc_hold), 32'(tbl[i].sel));
      chk("tbl_no_int", 32'(no_int), 32'(tbl[i].nint));
      chk("tbl_iter", 32'(iter_left), 32'(tbl[i].iter));
      chk("tbl_err", 32'(err), 32'(tbl[i].er));
      if (tbl[i].sel) chk("tbl_dout", 32'(cache_dout), 32'(tbl[i].dout));
      $display("vec %0d: sel=%0d no_int=%0d iter=%0d err=%0d dout=%h",
               i, cache_sel, no_int, iter_left, err, cache_dout);
    end

    // full-depth body, single pass, then redo K=1 replays all 15 once
    step(1, 1, {4'd15, 7'd1}, 0, 16'h0);
    for (int i = 0; i < 15; i++) step(1, 0, 11'h0, 1, 16'h1000 + 16'(i));
    chk("ni15_idle", 32'(no_int), 32'd0);
    step(1, 1, 11'h001, 0, 16'h0);
    for (int i = 0; i < 15; i++) begin
      chk("ni15_dout", 32'(cache_dout), 32'h1000 + 32'(i));
      chk("ni15_sel", 32'(cache_sel), 32'd1);
      step(1, 0, 11'h0, 1, 16'hFFFF);
    end
    chk("ni15_done", 32'(cache_sel), 32'd0);
    $display("ni15 sequence done");

    // reset in the middle of REPLAY with iter_left=5, then a fresh 2x2 loop
    step(1, 1, {4'd2, 7'd7}, 0, 16'h0);
    step(1, 0, 11'h0, 1, 16'h5A01);
    step(1, 0, 11'h0, 1, 16'h5A02);
    chk("mid_iter", 32'(iter_left), 32'd5);
    do_reset();
    chk("rst_iter", 32'(iter_left), 32'd0);
    step(1, 1, {4'd2, 7'd2}, 0, 16'h0);
    for (int i = 0; i < 4; i++) step(1, 0, 11'h0, 1, 16'h7700 + 16'(i));
    chk("post_rst_idle", 32'(no_int), 32'd0);
    $display("mid-replay reset sequence done");

    // randomized traffic
    for (int op = 0; op < 60; op++) begin
      int r, n;
      r = $urandom_range(0, 9);
      if (r == 0) do_reset();
      else if (r < 3) step(1, 1, {4'd0, 7'($urandom_range(0, 5))}, 1'($urandom), 16'($urandom));
      else step(1, 1, {4'($urandom_range(1, 15)), 7'($urandom_range(0, 6))}, 1'($urandom), 16'($urandom));
      n = 0;
      while (q.size() > 0 && n < 3000) begin
        if ($urandom_range(0, 199) == 0) do_reset();
        else step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                  11'($urandom), 1'($urandom_range(0, 2) != 0), 16'($urandom));
        n++;
      end
      if (n >= 3000) chk("timeout", 32'd1, 32'd0);
      step(1, 0, 11'h0, 0, 16'h0);
      $display("random op %0d: slots=%0d errors=%0d", op, n, errors);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtdsp16_do_cache.md
Name: jtdsp16_do_cache

Overview:
- Sequences the DSP16 instruction cache for the "do K {NI instructions}" and "redo K" forms.
- On the first pass it captures the loop body from the ROM fetch stream. It then replays the body K-1 more times from its internal 15-entry cache. During replay it holds the ROM program counter and drives the instruction mux.
- Sits between the program ROM fetch path and the control decoder. It consumes the decoder's do_start/do_data pulse and feeds cache_dout back to it.

Parameters:
- DEPTH, 15, number of cache entries; ISA-fixed maximum NI.
- DW, 16, instruction word width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cen  in  1  clock enable; all state advances only when cen=1.
- do_start  in  1  one-cen pulse from decoder: do/redo instruction decoded.
- do_data  in  11  [10:7]=NI (0 means redo), [6:0]=K loop count.
- inst_adv  in  1  the current fetch slot is consumed by the decoder this cen cycle.
- rom_dout  in  DW  instruction word from program ROM.
- cache_dout  out  DW  cached instruction at the replay pointer.
- cache_sel  out  1  decoder takes cache_dout instead of rom_dout.
- pc_hold  out  1  ROM PC must not advance.
- no_int  out  1  interrupts blocked (block busy).
- iter_left  out  7  replay passes still to run after the current one.
- err  out  1  one-cen pulse: illegal do/redo ignored.

Behaviour:
- Reset values:
  - cache_sel=0, pc_hold=0, no_int=0, iter_left=0, err=0, state=IDLE.
  - Pointer, NI latch and last_ni are all 0.
  - Cache RAM contents are not reset.
  - Reset asserted mid-operation aborts immediately to IDLE. A redo after reset is illegal because last_ni=0.
- States: IDLE, CAPTURE, REPLAY.
- IDLE, on cen & do_start:
  - NI>0: latch NI into last_ni, K into k_reg, ptr=0, go to CAPTURE.
  - NI=0 and last_ni>0: ptr=0, iter_left=K-1 (saturating at 0), go to REPLAY.
  - NI=0 and last_ni=0: err=1 for one cen cycle, stay IDLE.
- CAPTURE:
  - cache_sel=0, pc_hold=0, no_int=1.
  - Each cen & inst_adv: cache[ptr] <= rom_dout, ptr++.
  - When the write lands at ptr=last_ni-1:
    - K<=1: go to IDLE.
    - Otherwise: ptr=0, iter_left=K-2, go to REPLAY.
  - cen & inst_adv=0 holds ptr; no write.
- REPLAY:
  - cache_sel=1, pc_hold=1, no_int=1.
  - cache_dout = cache[ptr], combinational from the registered ptr.
  - Each cen & inst_adv: ptr++. At ptr=last_ni-1:
    - iter_left>0: ptr=0, iter_left--.
    - iter_left=0: go to IDLE; cache_sel/pc_hold drop on the same edge.
- Redo count: redo K replays exactly K passes (no capture pass). K=0 or K=1 gives one pass.
- do_start while not IDLE: ignored, err pulse, state unaffected.
- NI range: 1..15 only. The 4-bit field cannot exceed 15, so the cache cannot overflow.
- cen=0: all registers frozen, outputs stable.
- Latency:
  - State outputs change on the cen edge that samples the triggering event.
  - cache_dout is valid in the same cycle as cache_sel.
- last_ni persists across loops so that redo reuses the most recently captured body.

Test Plan:
- do NI=3 K=3, ROM feeds A,B,C with inst_adv=1 -> capture 3 cycles (cache_sel=0), then cache_dout sequence A,B,C,A,B,C with cache_sel=pc_hold=1; iter_left goes 1 then 0; IDLE after 9 total slots; no_int high throughout.
- Following redo K=2 (do_data=11'h002) -> 6 replay slots A,B,C,A,B,C, no ROM capture, then IDLE.
- redo immediately after reset -> err pulse, state stays IDLE, cache_sel=0.
- do NI=15 K=1 -> 15 captures, no replay, IDLE; a later redo K=1 replays all 15 entries once.
- REPLAY with inst_adv toggling 1,0,1 and cen gaps -> ptr advances only on cen&inst_adv; cache_dout stable otherwise.
- rst_n low in the middle of REPLAY (iter_left=5) -> outputs at reset values asynchronously; new do NI=2 K=2 after release runs normally.
